// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD request arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } sd_arb_state_t;

    localparam logic [23:0] SD_ARB_TIMEOUT_DEF = 24'd10000000;

endpackage

// File: rtl/sd_rr_pick.sv
// Round-robin pick: the first requester after 'last' (wrapping) that is asking.
module sd_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic            valid,
    output logic [1:0]      idx
);

    // Scan from the furthest offset to the nearest so the nearest asker wins.
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (((int'(last) + k) % NREQ) == i)) begin
                    valid = 1'b1;
                    idx   = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates up to four SD block requesters onto one SD interface.
// Optional feature: define SD_ARB_TIMEOUT_EN to abort requests that see no
// sd_ack within TIMEOUT clk_sys cycles (req_err pulse, then RELEASE).
//
// state   | meaning
// IDLE    | no owner; round-robin pick among pending requests
// ISSUE   | command driven to SD, waiting for ack_s to rise
// XFER    | ack_s high; ack and buffer strobes routed to the owner
// RELEASE | command dropped; waiting for the owner to drop rd/wr
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter logic [23:0] TIMEOUT = SD_ARB_TIMEOUT_DEF
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [32*NREQ-1:0]  req_lba,
    input  logic [NREQ-1:0]     req_rd,
    input  logic [NREQ-1:0]     req_wr,
    output logic [NREQ-1:0]     req_ack,
    output logic [NREQ-1:0]     req_buff_wr,
    input  logic [8*NREQ-1:0]   req_buff_din,
    output logic [NREQ-1:0]     req_err,
    output logic [31:0]         sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    input  logic                sd_buff_wr,
    output logic [7:0]          sd_buff_din,
    output logic [1:0]          grant,
    output logic                busy
);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT == 24'd0) begin : g_bad_cfg
        $error("sd_req_arbiter: NREQ must be 2..4 and TIMEOUT nonzero");
    end

    sd_arb_state_t state, state_nxt;
    logic          ack_m, ack_s, ack_q;
    logic          ack_rise, ack_fall;
    logic [1:0]    last_grant;
    logic [NREQ-1:0] req_any;
    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic [31:0]   pick_lba;
    logic          pick_rd, pick_wr;
    logic          own_req;
    logic          tmo_hit;

    assign req_any  = req_rd | req_wr;
    assign ack_rise = ack_s & ~ack_q;
    assign ack_fall = ~ack_s & ack_q;
    assign busy     = (state != IDLE);

    sd_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_any),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Two-flop synchronizer for sd_ack plus a delayed copy for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            ack_m <= sd_ack;
            ack_s <= ack_m;
            ack_q <= ack_s;
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] tmo_cnt;

    // Down-counter reloaded outside ISSUE; terminal count aborts the request.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= TIMEOUT;
        end else if (state == ISSUE) begin
            tmo_cnt <= tmo_cnt - 24'd1;
        end else begin
            tmo_cnt <= TIMEOUT;
        end
    end

    assign tmo_hit = (state == ISSUE) && (tmo_cnt == 24'd0);
`else
    assign tmo_hit = 1'b0;
`endif

    // Field muxes: picked requester for capture, owner for data and release.
    always_comb begin
        pick_lba    = '0;
        pick_rd     = 1'b0;
        pick_wr     = 1'b0;
        own_req     = 1'b0;
        sd_buff_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == 2'(i)) begin
                pick_lba = req_lba[32*i +: 32];
                pick_rd  = req_rd[i];
                pick_wr  = req_wr[i];
            end
            if (grant == 2'(i)) begin
                own_req     = req_rd[i] | req_wr[i];
                sd_buff_din = req_buff_din[8*i +: 8];
            end
        end
    end

    // Next state and per-requester routing of ack, strobe and abort.
    always_comb begin
        state_nxt   = state;
        req_ack     = '0;
        req_buff_wr = '0;
        req_err     = '0;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   if (tmo_hit) state_nxt = RELEASE;
                     else if (ack_rise) state_nxt = XFER;
            XFER:    if (ack_fall) state_nxt = RELEASE;
            RELEASE: if (!own_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        for (int i = 0; i < NREQ; i++) begin
            if (grant == 2'(i)) begin
                if (state == XFER) begin
                    req_ack[i]     = ack_s;
                    req_buff_wr[i] = sd_buff_wr;
                end
                if (tmo_hit) req_err[i] = 1'b1;
            end
        end
    end

    // State register, owner and round-robin pointer.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'(NREQ - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_valid) begin
                grant      <= pick_idx;
                last_grant <= pick_idx;
            end
        end
    end

    // Command captured at grant, held through ISSUE/XFER, cleared on exit.
    // A requester asking for both read and write is issued a read.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sd_lba <= '0;
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
        end else if (state == IDLE && pick_valid) begin
            sd_lba <= pick_lba;
            sd_rd  <= pick_rd;
            sd_wr  <= pick_wr & ~pick_rd;
        end else if (state_nxt == RELEASE || state_nxt == IDLE) begin
            sd_lba <= '0;
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
        end
    end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of SD block requesters (2..4).
REQ-002 The block SHALL have parameter TIMEOUT, default 24'd10000000, giving the clk_sys cycles allowed to wait for sd_ack before an abort.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: clk_sys  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these requester ports:
- req_lba  in  32*NREQ  per-requester LBA.
- req_rd  in  NREQ  per-requester read request.
- req_wr  in  NREQ  per-requester write request.
- req_ack  out  NREQ  per-requester ack.
- req_buff_wr  out  NREQ  per-requester buffer write strobe.
- req_buff_din  in  8*NREQ  per-requester buffer read data.
- req_err  out  NREQ  one-cycle abort pulse.
REQ-005 The block SHALL have these ports toward the SD interface:
- sd_lba  out  32  granted LBA.
- sd_rd  out  1  granted read.
- sd_wr  out  1  granted write.
- sd_ack  in  1  ack (SPI_SCK domain).
- sd_buff_wr  in  1  write strobe.
- sd_buff_din  out  8  muxed buffer read data.
- grant  out  2  current owner index.
- busy  out  1  a request is in progress.

Function
REQ-006 The block SHALL pass sd_ack through a 2-flop synchronizer into clk_sys to give ack_s; all decisions SHALL use ack_s.
REQ-007 The state machine SHALL have the states IDLE, ISSUE, XFER and RELEASE.
REQ-008 In IDLE, when any requester's (req_rd|req_wr) is high, the block SHALL round-robin select starting at (last grant + 1) mod NREQ, latch grant, and enter ISSUE on the next cycle.
REQ-009 The block SHALL register sd_lba, sd_rd and sd_wr from the granted requester (1-cycle latency) and hold them stable while in ISSUE and XFER; they SHALL be 0 in IDLE and RELEASE.
REQ-010 The block SHALL move from ISSUE to XFER on the rising edge of ack_s.
REQ-011 The block SHALL move from XFER to RELEASE on the falling edge of ack_s.
REQ-012 The block SHALL move from RELEASE to IDLE once the granted requester's rd and wr are both low.
REQ-013 req_ack[grant] SHALL equal ack_s while in XFER and be 0 otherwise; ack for non-granted requesters SHALL be 0.
REQ-014 req_buff_wr[grant] SHALL equal sd_buff_wr combinationally while in XFER; the strobe SHALL be 0 for all other requesters and states.
REQ-015 sd_buff_din SHALL equal req_buff_din[grant] combinationally at all times.
REQ-016 busy SHALL be high in every state except IDLE.
REQ-017 If the granted requester drops rd/wr while in ISSUE, the block SHALL keep the request asserted until the transfer completes (no mid-sector cancel).
REQ-018 Requests arriving during a transfer SHALL be held pending and arbitrated in the next IDLE; no request SHALL be lost.
REQ-019 If rd and wr are both high on the same requester, the block SHALL treat it as a read.

Reset
REQ-020 While reset_n is low, the block SHALL force the state to IDLE; grant, sd_lba, sd_rd, sd_wr, req_ack, req_err and busy to 0; last grant to NREQ-1; the synchronizer to 0.
REQ-021 If reset occurs mid-transfer, the block SHALL drop sd_rd/sd_wr immediately and not resume the transfer.

Configuration
REQ-022 With SD_ARB_TIMEOUT_EN defined, a 24-bit counter SHALL run in ISSUE and, on reaching TIMEOUT, the block SHALL pulse req_err[grant] for one cycle, drop sd_rd/sd_wr, and go to RELEASE.
REQ-023 Without SD_ARB_TIMEOUT_EN, no counter SHALL exist, req_err SHALL be constant 0, and ISSUE SHALL wait indefinitely.

Structure
REQ-024 The shared package sd_arb_pkg SHALL hold the state enum (IDLE=0, ISSUE=1, XFER=2, RELEASE=3) and the default TIMEOUT constant.
REQ-025 The round-robin priority selection SHALL be implemented as the sub-module sd_rr_pick (inputs: request vector and last grant; outputs: valid and index).

Verification
REQ-026 The bench SHALL cover a single read: req_rd[0]=1, lba=0x1234 -> sd_rd=1 and sd_lba=0x1234 on the 2nd cycle; ack high for 600 cycles with 512 sd_buff_wr pulses -> exactly 512 req_buff_wr[0] pulses and 0 on req_buff_wr[1].
REQ-027 The bench SHALL cover simultaneous requests: rd[0] and wr[1] asserted in the same cycle with last grant=1 -> requester 0 served first, requester 1 served next with sd_wr=1.
REQ-028 The bench SHALL cover fairness: requester 0 re-requests continuously while 1 is pending -> grants alternate 0,1,0,1.
REQ-029 The bench SHALL cover a write: sd_buff_din equals req_buff_din[1]=0xA5 while grant=1.
REQ-030 The bench SHALL cover a timeout with SD_ARB_TIMEOUT_EN defined and TIMEOUT=100, no ack -> req_err[0] pulses at cycle 101 in ISSUE, sd_rd=0, then IDLE after rd drops.
REQ-031 The bench SHALL cover reset mid-transfer: reset_n low during XFER -> sd_rd=0, busy=0 and grant=0 asynchronously.
